// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared audio-path types and defaults for the codec capture and
//               playback blocks (sample/address widths, SRAM end, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int unsigned c_data_w    = 16;
    localparam int unsigned c_addr_w    = 18;
    // Last writable SRAM word; also the playback block's end-of-buffer mark.
    localparam int unsigned c_last_addr = (1 << c_addr_w) - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DELAY = 3'd2,
        ST_SHIFT = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5
    } rec_state_t;

endpackage
`default_nettype wire

// File: rtl/lrc_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : lrc_edge_det
// Description : Registers the codec frame clock once and flags its rising and
//               falling edges in the bit-clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module lrc_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic lrc,
    output logic rise,
    output logic fall
);

    logic lrc_d;
    logic lrc_q;

    always_comb begin
        lrc_d = lrc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_q <= 1'b0;
        end else begin
            lrc_q <= lrc_d;
        end
    end

    assign rise = ~lrc_q & lrc;
    assign fall = lrc_q & ~lrc;

endmodule
`default_nettype wire

// File: rtl/adc_recorder.sv
`default_nettype none
// ============================================================================
// Module      : adc_recorder
// Description : Deserializes codec ADC samples and writes them to consecutive
//               SRAM addresses while record is high. ADC_STEREO_EN adds
//               interleaved right-channel capture.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_recorder
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W    = c_data_w,
    parameter int unsigned ADDR_W    = c_addr_w,
    parameter int unsigned LAST_ADDR = c_last_addr,
    parameter int unsigned LRC_DELAY = 1
) (
    input  logic              bclk,
    input  logic              rst_n,
    input  logic              record,
    input  logic              adclrc,
    input  logic              adcdat,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_o,
    output logic              wr_o,
    output logic              done,
    output logic [4:0]        bitcnt_o
);

    localparam int unsigned       c_dly_w     = (LRC_DELAY > 1) ? $clog2(LRC_DELAY) : 1;
    localparam logic [ADDR_W-1:0] c_last      = ADDR_W'(LAST_ADDR);
    localparam logic [4:0]        c_bit_last  = 5'(DATA_W - 1);

    rec_state_t           state_d, state_q;
    logic [ADDR_W-1:0]    addr_d, addr_q;
    logic [DATA_W-1:0]    data_d, data_q;
    logic [DATA_W-2:0]    shift_d, shift_q;
    logic [4:0]           bitcnt_d, bitcnt_q;
    logic [c_dly_w-1:0]   dly_d, dly_q;
    logic [DATA_W-1:0]    w_shift_in;
    logic                 w_fall;
    logic                 w_sync_edge;

`ifdef ADC_STEREO_EN
    logic w_rise;
    logic chan_d, chan_q;

    lrc_edge_det u_lrc_edge (
        .clk   (bclk),
        .rst_n (rst_n),
        .lrc   (adclrc),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // Right channel starts on the rising frame edge, left on the falling one.
    assign w_sync_edge = chan_q ? w_rise : w_fall;
`else
    lrc_edge_det u_lrc_edge (
        .clk   (bclk),
        .rst_n (rst_n),
        .lrc   (adclrc),
        .rise  (),
        .fall  (w_fall)
    );

    assign w_sync_edge = w_fall;
`endif

    assign w_shift_in = {shift_q, adcdat};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        dly_d    = dly_q;
`ifdef ADC_STEREO_EN
        chan_d   = chan_q;
`endif
        if (!record) begin
            // Any partial sample is dropped; nothing is written on the way out.
            state_d  = ST_IDLE;
            bitcnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    addr_d   = '0;
                    bitcnt_d = '0;
`ifdef ADC_STEREO_EN
                    chan_d   = 1'b0;
`endif
                    state_d  = ST_SYNC;
                end
                ST_SYNC: begin
                    if (w_sync_edge) begin
                        if (LRC_DELAY == 0) begin
                            shift_d  = w_shift_in[DATA_W-2:0];
                            bitcnt_d = 5'd1;
                            state_d  = ST_SHIFT;
                        end else begin
                            dly_d    = c_dly_w'(LRC_DELAY - 1);
                            state_d  = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_q == '0) begin
                        shift_d  = w_shift_in[DATA_W-2:0];
                        bitcnt_d = 5'd1;
                        state_d  = ST_SHIFT;
                    end else begin
                        dly_d    = dly_q - c_dly_w'(1);
                    end
                end
                ST_SHIFT: begin
                    shift_d = w_shift_in[DATA_W-2:0];
                    if (bitcnt_q == c_bit_last) begin
                        data_d   = w_shift_in;
                        bitcnt_d = '0;
                        state_d  = ST_STORE;
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end
                ST_STORE: begin
                    if (addr_q == c_last) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
`ifdef ADC_STEREO_EN
                        chan_d  = ~chan_q;
`endif
                        state_d = ST_SYNC;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            dly_q    <= '0;
`ifdef ADC_STEREO_EN
            chan_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            dly_q    <= dly_d;
`ifdef ADC_STEREO_EN
            chan_q   <= chan_d;
`endif
        end
    end

    // The playback block owns the bus whenever recording is off.
    assign addr     = record ? addr_q : 'z;
    assign data_o   = data_q;
    assign wr_o     = record & (state_q == ST_STORE);
    assign done     = record & (state_q == ST_DONE);
    assign bitcnt_o = bitcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_recorder
// Description : Self-checking bench for adc_recorder: an I2S instance and a
//               left-justified instance with a tiny SRAM share one codec stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_recorder;

    localparam int c_last_i2s = (1 << 18) - 1;
    localparam int c_last_lj  = 3;

    logic bclk   = 1'b0;
    logic rst_n  = 1'b1;
    logic record = 1'b0;
    logic adclrc = 1'b1;
    logic adcdat = 1'b0;

    wire  [17:0] addr_i2s;
    wire  [17:0] addr_lj;
    logic [15:0] data_i2s, data_lj;
    logic        wr_i2s, wr_lj, done_i2s, done_lj;
    logic [4:0]  bc_i2s, bc_lj;

    always #5 bclk = ~bclk;

    adc_recorder #(
        .DATA_W    (16),
        .ADDR_W    (18),
        .LAST_ADDR (c_last_i2s),
        .LRC_DELAY (1)
    ) u_i2s (
        .bclk     (bclk),
        .rst_n    (rst_n),
        .record   (record),
        .adclrc   (adclrc),
        .adcdat   (adcdat),
        .addr     (addr_i2s),
        .data_o   (data_i2s),
        .wr_o     (wr_i2s),
        .done     (done_i2s),
        .bitcnt_o (bc_i2s)
    );

    adc_recorder #(
        .DATA_W    (16),
        .ADDR_W    (18),
        .LAST_ADDR (c_last_lj),
        .LRC_DELAY (0)
    ) u_lj (
        .bclk     (bclk),
        .rst_n    (rst_n),
        .record   (record),
        .adclrc   (adclrc),
        .adcdat   (adcdat),
        .addr     (addr_lj),
        .data_o   (data_lj),
        .wr_o     (wr_lj),
        .done     (done_lj),
        .bitcnt_o (bc_lj)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [33:0] exp_i2s[$];
    logic [33:0] exp_lj[$];
    int          cnt_i2s  = 0;
    int          cnt_lj   = 0;
    logic [15:0] got_i2s[$];
    logic [15:0] got_lj[$];
    logic [17:0] last_addr_i2s = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // A half-frame is 32 bits, bit 31 on the first bclk after the frame edge;
    // a receiver skipping d bclks takes the next 16 bits MSB first.
    function automatic logic [15:0] pick(input logic [31:0] hb, input int d);
        return hb[31-d -: 16];
    endfunction

    task automatic model_half(input logic [31:0] hb);
        if (cnt_i2s <= c_last_i2s) begin
            exp_i2s.push_back({18'(cnt_i2s), pick(hb, 1)});
            cnt_i2s++;
        end
        if (cnt_lj <= c_last_lj) begin
            exp_lj.push_back({18'(cnt_lj), pick(hb, 0)});
            cnt_lj++;
        end
    endtask

    task automatic set_record(input logic v);
        if (record != v) begin
            cnt_i2s = 0;
            cnt_lj  = 0;
        end
        record = v;
        #1;
        if (!v) begin
            chk("i2s_done_clear", 64'(done_i2s), 64'd0);
            chk("lj_done_clear",  64'(done_lj),  64'd0);
            chk("i2s_wr_clear",   64'(wr_i2s),   64'd0);
        end
    endtask

    task automatic run_frame(input logic [31:0] lb, input logic [31:0] rb,
                             input bit abort, input logic rec_next);
        if (record && !abort) begin
            model_half(lb);
`ifdef ADC_STEREO_EN
            model_half(rb);
`endif
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge bclk);
            adclrc = (k >= 32);
            adcdat = (k < 32) ? lb[31-k] : rb[63-k];
            if (abort && k == 8) set_record(1'b0);
            if (k == 56) set_record(rec_next);
        end
        #1;
        chk("i2s_missing_wr", 64'(exp_i2s.size()), 64'd0);
        chk("lj_missing_wr",  64'(exp_lj.size()),  64'd0);
        chk("lj_done", 64'(done_lj), 64'(record && (cnt_lj > c_last_lj)));
        chk("i2s_done", 64'(done_i2s), 64'(record && (cnt_i2s > c_last_i2s)));
        exp_i2s.delete();
        exp_lj.delete();
    endtask

    // Per-cycle compare of write strobes against the expected write streams.
    initial begin
        logic [33:0] e;
        forever begin
            @(posedge bclk);
            #2;
            if (wr_i2s) begin
                if (exp_i2s.size() == 0) begin
                    chk("i2s_unexpected_wr", 64'(wr_i2s), 64'd0);
                end else begin
                    e = exp_i2s.pop_front();
                    chk("i2s_wr_addr", 64'(addr_i2s), 64'(e[33:16]));
                    chk("i2s_wr_data", 64'(data_i2s), 64'(e[15:0]));
                    got_i2s.push_back(data_i2s);
                    last_addr_i2s = addr_i2s;
                end
            end
            if (wr_lj) begin
                if (exp_lj.size() == 0) begin
                    chk("lj_unexpected_wr", 64'(wr_lj), 64'd0);
                end else begin
                    e = exp_lj.pop_front();
                    chk("lj_wr_addr", 64'(addr_lj), 64'(e[33:16]));
                    chk("lj_wr_data", 64'(data_lj), 64'(e[15:0]));
                    got_lj.push_back(data_lj);
                end
            end
            if (!record) begin
                chk("idle_no_wr",   64'({wr_i2s, wr_lj}),     64'd0);
                chk("idle_no_done", 64'({done_i2s, done_lj}), 64'd0);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge bclk);
        chk("rst_wr",     64'({wr_i2s, wr_lj}),     64'd0);
        chk("rst_done",   64'({done_i2s, done_lj}), 64'd0);
        chk("rst_data",   64'({data_i2s, data_lj}), 64'd0);
        chk("rst_bitcnt", 64'({bc_i2s, bc_lj}),     64'd0);
        rst_n = 1'b1;

        run_frame($urandom, $urandom, 1'b0, 1'b1);
        run_frame({1'b0, 16'hA5C3, 15'h0}, {1'b0, 16'h8000, 15'h0}, 1'b0, 1'b1);
        run_frame({1'b0, 16'h1234, 15'h0}, $urandom, 1'b0, 1'b1);
        run_frame({16'hA5C3, 16'h0}, $urandom, 1'b0, 1'b1);
`ifdef ADC_STEREO_EN
        chk("lit_i2s0", 64'(got_i2s[0]), 64'h0000_0000_0000_A5C3);
        chk("lit_i2s1", 64'(got_i2s[1]), 64'h0000_0000_0000_8000);
        chk("lit_i2s2", 64'(got_i2s[2]), 64'h0000_0000_0000_1234);
        chk("lit_lj0",  64'(got_lj[0]),  64'h0000_0000_0000_52E1);
        chk("lit_lj1",  64'(got_lj[1]),  64'h0000_0000_0000_4000);
        chk("lit_lj2",  64'(got_lj[2]),  64'h0000_0000_0000_091A);
`else
        chk("lit_i2s0", 64'(got_i2s[0]), 64'h0000_0000_0000_A5C3);
        chk("lit_i2s1", 64'(got_i2s[1]), 64'h0000_0000_0000_1234);
        chk("lit_i2s2", 64'(got_i2s[2]), 64'h0000_0000_0000_4B86);
        chk("lit_lj0",  64'(got_lj[0]),  64'h0000_0000_0000_52E1);
        chk("lit_lj1",  64'(got_lj[1]),  64'h0000_0000_0000_091A);
        chk("lit_lj2",  64'(got_lj[2]),  64'h0000_0000_0000_A5C3);
`endif
        run_frame($urandom, $urandom, 1'b0, 1'b1);
        chk("lit_lj_full_done", 64'(done_lj), 64'd1);
        run_frame($urandom, $urandom, 1'b0, 1'b0);
        chk("lit_lj_total_writes", 64'(got_lj.size()), 64'd4);
        run_frame($urandom, $urandom, 1'b0, 1'b1);
        run_frame($urandom, $urandom, 1'b1, 1'b1);
        run_frame($urandom, $urandom, 1'b0, 1'b1);
`ifdef ADC_STEREO_EN
        chk("lit_restart_addr", 64'(last_addr_i2s), 64'd1);
`else
        chk("lit_restart_addr", 64'(last_addr_i2s), 64'd0);
`endif

        for (int f = 0; f < 30; f++) begin
            bit   ab;
            logic rn;
            ab = record && ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 5) != 0);
            run_frame($urandom, $urandom, ab, rn);
        end
        run_frame($urandom, $urandom, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a left-channel word.
        for (int k = 0; k < 10; k++) begin
            @(negedge bclk);
            adclrc = 1'b0;
            adcdat = 1'($urandom);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midshift_rst_wr",   64'({wr_i2s, wr_lj}),     64'd0);
        chk("midshift_rst_done", 64'({done_i2s, done_lj}), 64'd0);
        chk("midshift_rst_data", 64'({data_i2s, data_lj}), 64'd0);
        chk("midshift_rst_addr", 64'({addr_i2s, addr_lj}), 64'd0);
        record = 1'b0;
        #1;
        chk("rst_rec_off_done", 64'({done_i2s, done_lj}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
